// File: rtl/aib_flit_packer_if.sv
// aib_flit_packer_if
// Groups the message-side valid/ready channel, the adapter transmit bus and
// the completed-message counter of aib_flit_packer into one bundle.
//   master : core/adapter side (drives messages and tx ready, observes flits)
//   slave  : the packer itself
// Signals:
//   i_msg_valid / o_msg_ready      message handshake
//   i_msg_data                     payload, beat k = bits [64k+63:64k]
//   i_msg_beats_m1                 number of beats minus 1
//   i_msg_chan                     4-bit channel ID
//   o_bus_tx_valid / i_bus_tx_ready  flit handshake toward the adapter
//   o_bus_tx_data                  72-bit flit {sop, eop, seq[1:0], chan[3:0], payload[63:0]}
//   o_msg_count                    count of fully transmitted messages
interface aib_flit_packer_if #(
    parameter int unsigned MAX_BEATS = 4,
    parameter int unsigned BW        = $clog2(MAX_BEATS)
);
    logic                      i_msg_valid;
    logic                      o_msg_ready;
    logic [64*MAX_BEATS-1:0]   i_msg_data;
    logic [BW-1:0]             i_msg_beats_m1;
    logic [3:0]                i_msg_chan;
    logic                      o_bus_tx_valid;
    logic                      i_bus_tx_ready;
    logic [71:0]               o_bus_tx_data;
    logic [15:0]               o_msg_count;

    modport master (
        output i_msg_valid, i_msg_data, i_msg_beats_m1, i_msg_chan, i_bus_tx_ready,
        input  o_msg_ready, o_bus_tx_valid, o_bus_tx_data, o_msg_count
    );

    modport slave (
        input  i_msg_valid, i_msg_data, i_msg_beats_m1, i_msg_chan, i_bus_tx_ready,
        output o_msg_ready, o_bus_tx_valid, o_bus_tx_data, o_msg_count
    );
endinterface

// File: rtl/aib_flit_packer.sv
// aib_flit_packer
// Splits 1..MAX_BEATS-beat messages into 72-bit flits for the AIB adapter
// transmit bus. Each flit carries {sop, eop, seq, chan} plus one 64-bit beat.
// Messages stream back-to-back: a new message is accepted in the same cycle
// as the EOP flit handshake.
// Ports:
//   i_bus_clk  sole clock, rising edge
//   i_rst_n    synchronous active-low reset
//   bus        aib_flit_packer_if.slave (message in, flit out, message count)
module aib_flit_packer #(
    parameter int unsigned MAX_BEATS = 4,
    parameter int unsigned BW        = $clog2(MAX_BEATS)
) (
    input logic              i_bus_clk,
    input logic              i_rst_n,
    aib_flit_packer_if.slave bus
);

    typedef enum logic {StIdle, StSend} state_e;

    state_e         state_q;
    logic [63:0]    msg_q [MAX_BEATS];
    logic [BW-1:0]  beats_m1_q;
    logic [BW-1:0]  beat_q;
    logic [3:0]     chan_q;
    logic [1:0]     seq_q;
    logic [15:0]    count_q;
    logic           rst_n_q;

    logic last_beat;
    logic tx_fire;
    logic msg_ready;
    logic accept;

    assign last_beat = (beat_q == beats_m1_q);
    assign tx_fire   = (state_q == StSend) && bus.i_bus_tx_ready;

    // rst_n_q keeps the block from accepting in the first cycle after release.
    // The tx_ready term lets the next message land on the EOP handshake edge.
    assign msg_ready = rst_n_q && ((state_q == StIdle) || (tx_fire && last_beat));
    assign accept    = bus.i_msg_valid && msg_ready;

    always_ff @(posedge i_bus_clk) begin
        rst_n_q <= i_rst_n;
        if (!i_rst_n) begin
            state_q <= StIdle;
            beat_q  <= '0;
            seq_q   <= 2'd0;
            count_q <= 16'd0;
        end else begin
            if (tx_fire) begin
                if (last_beat) begin
                    seq_q   <= seq_q + 2'd1;
                    count_q <= count_q + 16'd1;
                    state_q <= StIdle;
                end else begin
                    beat_q <= beat_q + 1'b1;
                end
            end
            // A same-cycle accept overrides the return to idle above.
            if (accept) begin
                beat_q  <= '0;
                state_q <= StSend;
            end
        end
    end

    // Payload and channel registers carry no reset; they are only read in StSend.
    always_ff @(posedge i_bus_clk) begin
        if (accept) begin
            for (int k = 0; k < int'(MAX_BEATS); k++) begin
                msg_q[k] <= bus.i_msg_data[64*k +: 64];
            end
            beats_m1_q <= bus.i_msg_beats_m1;
            chan_q     <= bus.i_msg_chan;
        end
    end

    assign bus.o_msg_ready    = msg_ready;
    assign bus.o_bus_tx_valid = (state_q == StSend);
    assign bus.o_bus_tx_data  = {(beat_q == '0), last_beat, seq_q, chan_q, msg_q[beat_q]};
    assign bus.o_msg_count    = count_q;

endmodule

// File: tb/tb_aib_flit_packer.sv
// tb_aib_flit_packer
// Directed stimulus for aib_flit_packer with a queue-based reference model:
// every accepted message is expanded into its expected flits, and a negedge
// compare process checks valid, ready, data and message count each cycle.
module tb_aib_flit_packer;
    localparam int unsigned MAX_BEATS = 4;
    localparam int unsigned BW        = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    aib_flit_packer_if #(.MAX_BEATS(MAX_BEATS), .BW(BW)) bus_if ();

    aib_flit_packer #(.MAX_BEATS(MAX_BEATS), .BW(BW)) dut (
        .i_bus_clk (clk),
        .i_rst_n   (rst_n),
        .bus       (bus_if.slave)
    );

    int checks   = 0;
    int failures = 0;

    logic [71:0] exp_q    [$];
    logic [71:0] flit_log [$];
    logic [1:0]  m_seq    = 2'd0;
    logic [15:0] m_count  = 16'd0;
    logic        m_rstq   = 1'b0;
    bit          mon_en   = 1'b0;

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model plus per-cycle compare.
    always @(negedge clk) begin : mon
        logic        exp_valid;
        logic        exp_ready;
        logic [71:0] f;
        int          nb;
        if (mon_en) begin
            exp_valid = (exp_q.size() != 0);
            exp_ready = m_rstq && (exp_q.size() == 0 ||
                                   (exp_q[0][70] && bus_if.i_bus_tx_ready));
            check("tx_valid", 72'(bus_if.o_bus_tx_valid), 72'(exp_valid));
            check("msg_ready", 72'(bus_if.o_msg_ready), 72'(exp_ready));
            check("msg_count", 72'(bus_if.o_msg_count), 72'(m_count));
            if (exp_valid) check("tx_data", bus_if.o_bus_tx_data, exp_q[0]);

            if (rst_n && bus_if.o_bus_tx_valid && bus_if.i_bus_tx_ready)
                flit_log.push_back(bus_if.o_bus_tx_data);

            if (!rst_n) begin
                exp_q.delete();
                m_seq   = 2'd0;
                m_count = 16'd0;
            end else begin
                if (exp_valid && bus_if.i_bus_tx_ready) begin
                    f = exp_q.pop_front();
                    if (f[70]) m_count = m_count + 16'd1;
                end
                if (bus_if.i_msg_valid && exp_ready) begin
                    nb = int'(bus_if.i_msg_beats_m1) + 1;
                    for (int k = 0; k < nb; k++) begin
                        f[71]    = (k == 0);
                        f[70]    = (k == nb - 1);
                        f[69:68] = m_seq;
                        f[67:64] = bus_if.i_msg_chan;
                        f[63:0]  = bus_if.i_msg_data[64*k +: 64];
                        exp_q.push_back(f);
                    end
                    m_seq = m_seq + 2'd1;
                end
            end
            m_rstq = rst_n;
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cycles(2);
        rst_n = 1'b1;
        cycles(2);
    endtask

    // Offers a message and returns just after the accepting edge.
    task automatic send_msg(input logic [255:0] data, input logic [1:0] bm1,
                            input logic [3:0] chan);
        bit got;
        got = 1'b0;
        bus_if.i_msg_valid    = 1'b1;
        bus_if.i_msg_data     = data;
        bus_if.i_msg_beats_m1 = bm1;
        bus_if.i_msg_chan     = chan;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (bus_if.o_msg_ready) got = 1'b1;
        end
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: msg_ready stayed 0, required 1 within 50 cycles");
        end
        @(posedge clk);
        #1;
        bus_if.i_msg_valid = 1'b0;
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] d4;
        logic [7:0]   hdr [6];
        logic [3:0]   bp_pat;
        logic [5:0]   pat;

        bus_if.i_msg_valid    = 1'b1;
        bus_if.i_msg_data     = '0;
        bus_if.i_msg_beats_m1 = '0;
        bus_if.i_msg_chan     = '0;
        bus_if.i_bus_tx_ready = 1'b1;
        rst_n = 1'b0;

        // Reset and start-up
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            mon_en = 1'b1;
            @(negedge clk);
            check("rst_msg_ready", 72'(bus_if.o_msg_ready), 72'd0);
            check("rst_tx_valid", 72'(bus_if.o_bus_tx_valid), 72'd0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("release_msg_ready", 72'(bus_if.o_msg_ready), 72'd0);
        check("release_tx_valid", 72'(bus_if.o_bus_tx_valid), 72'd0);
        @(posedge clk);
        #1;
        bus_if.i_msg_valid = 1'b0;
        @(negedge clk);
        check("startup_msg_ready", 72'(bus_if.o_msg_ready), 72'd1);
        check("startup_count", 72'(bus_if.o_msg_count), 72'd0);

        // Single 4-beat message
        @(posedge clk);
        #1;
        flit_log.delete();
        d4 = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
              64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        send_msg(d4, 2'd3, 4'hA);
        cycles(6);
        check("m4_flits", 72'(flit_log.size()), 72'd4);
        if (flit_log.size() == 4) begin
            check("m4_hdr0", 72'(flit_log[0][71:64]), 72'h8A);
            check("m4_hdr1", 72'(flit_log[1][71:64]), 72'h0A);
            check("m4_hdr2", 72'(flit_log[2][71:64]), 72'h0A);
            check("m4_hdr3", 72'(flit_log[3][71:64]), 72'h4A);
            check("m4_pay1", 72'(flit_log[1][63:0]), 72'h2222_2222_2222_2222);
        end
        check("m4_count", 72'(bus_if.o_msg_count), 72'd1);

        // Back-to-back single-beat messages
        do_reset();
        flit_log.delete();
        for (int i = 0; i < 6; i++) send_msg(256'(64'hA0 + i), 2'd0, 4'h5);
        cycles(3);
        hdr[0] = 8'hC5; hdr[1] = 8'hD5; hdr[2] = 8'hE5;
        hdr[3] = 8'hF5; hdr[4] = 8'hC5; hdr[5] = 8'hD5;
        check("b2b_flits", 72'(flit_log.size()), 72'd6);
        if (flit_log.size() == 6) begin
            for (int i = 0; i < 6; i++) check("b2b_hdr", 72'(flit_log[i][71:64]), 72'(hdr[i]));
        end
        check("b2b_count", 72'(bus_if.o_msg_count), 72'd6);

        // Backpressure on a 3-beat message
        do_reset();
        flit_log.delete();
        bus_if.i_bus_tx_ready = 1'b0;
        d4 = {64'h0, 64'hCCCC_0003, 64'hBBBB_0002, 64'hAAAA_0001};
        send_msg(d4, 2'd2, 4'h3);
        pat = 6'b110100;  // applied LSB first: 0,0,1,0,1,1
        for (int p = 0; p < 6; p++) begin
            bus_if.i_bus_tx_ready = pat[p];
            @(posedge clk);
            #1;
        end
        bus_if.i_bus_tx_ready = 1'b1;
        cycles(2);
        check("bp_flits", 72'(flit_log.size()), 72'd3);
        if (flit_log.size() == 3) begin
            check("bp_flit0", flit_log[0], {8'h83, 64'hAAAA_0001});
            check("bp_flit1", flit_log[1], {8'h03, 64'hBBBB_0002});
            check("bp_flit2", flit_log[2], {8'h43, 64'hCCCC_0003});
        end
        check("bp_count", 72'(bus_if.o_msg_count), 72'd1);

        // Reset mid-message
        do_reset();
        send_msg(256'h0, 2'd0, 4'h1);  // advances seq so the post-reset seq=0 means something
        cycles(2);
        flit_log.delete();
        d4 = {64'h44, 64'h33, 64'h22, 64'h11};
        send_msg(d4, 2'd3, 4'h7);
        @(posedge clk);
        #1;
        bus_if.i_bus_tx_ready = 1'b0;
        rst_n = 1'b0;
        cycles(2);
        rst_n = 1'b1;
        bus_if.i_bus_tx_ready = 1'b1;
        cycles(2);
        check("rst_mid_flits", 72'(flit_log.size()), 72'd1);
        check("rst_mid_count", 72'(bus_if.o_msg_count), 72'd0);
        send_msg({128'h0, 64'h99, 64'h88}, 2'd1, 4'h2);
        cycles(3);
        check("rst_mid_flits2", 72'(flit_log.size()), 72'd3);
        if (flit_log.size() == 3) begin
            check("rst_mid_hdr", 72'(flit_log[1][71:64]), 72'h82);
            check("rst_mid_eop", 72'(flit_log[2][71:64]), 72'h42);
        end
        check("rst_mid_count2", 72'(bus_if.o_msg_count), 72'd1);

        // Counter wrap over 65536 single-beat messages
        do_reset();
        flit_log.delete();
        for (int i = 0; i < 65536; i++) send_msg(256'(i), 2'd0, 4'(i));
        cycles(3);
        check("wrap_count", 72'(bus_if.o_msg_count), 72'd0);
        check("wrap_flits", 72'(flit_log.size()), 72'd65536);
        if (flit_log.size() == 65536) begin
            check("wrap_last_hdr", 72'(flit_log[65535][71:64]), 72'hFF);
            check("wrap_mid_hdr", 72'(flit_log[1026][71:64]), 72'hE2);
        end
        send_msg(256'h5, 2'd0, 4'h4);
        cycles(2);
        check("wrap_next_count", 72'(bus_if.o_msg_count), 72'd1);
        check("wrap_next_hdr", 72'(flit_log[flit_log.size()-1][71:64]), 72'hC4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
